// File: rtl/seq_mod_red.sv
// Sequential modular reducer: x mod m, one operand bit per cycle, MSB first.
// Moduli: ed25519 field prime q, group order l, or an external value.
module seq_mod_red #(
  parameter int IN_W  = 512,
  parameter int OUT_W = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IN_W-1:0]  x,
  input  logic [1:0]       mode,
  input  logic [OUT_W-1:0] m_ext,
  output logic             busy,
  output logic             done,
  output logic [OUT_W-1:0] mod,
  output logic             err
);

  localparam int CW = $clog2(IN_W);

  localparam logic [255:0] Q_C =
    256'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed;
  localparam logic [255:0] L_C =
    256'h10000000_00000000_00000000_00000000_14def9de_a2f79cd6_5812631a_5cf5d3ed;

  localparam logic [OUT_W-1:0] Q_M = OUT_W'(Q_C);
  localparam logic [OUT_W-1:0] L_M = OUT_W'(L_C);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  state_t           state_q, state_d;
  logic [IN_W-1:0]  x_q, x_d;
  logic [OUT_W-1:0] m_q, m_d;
  logic [OUT_W-1:0] r_q, r_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [OUT_W-1:0] mod_q, mod_d;

  logic [OUT_W-1:0] m_sel;
  logic [OUT_W:0]   t;
  logic             t_ge;
  logic [OUT_W-1:0] t_diff;
  logic [OUT_W-1:0] r_nxt;

  // Resolve the modulus selected by mode at the time of capture.
  always_comb begin
    m_sel = Q_M;
    unique case (mode)
      2'd0: m_sel = Q_M;
      2'd1: m_sel = L_M;
      2'd2: m_sel = m_ext;
      2'd3: m_sel = Q_M;
    endcase
  end

  // One shift-and-subtract step; the carry bit t[OUT_W] forces t >= m.
  always_comb begin
    t      = {r_q, x_q[IN_W-1]};
    t_ge   = t[OUT_W] | (t[OUT_W-1:0] >= m_q);
    t_diff = t[OUT_W-1:0] - m_q;
    r_nxt  = t_ge ? t_diff : t[OUT_W-1:0];
  end

  // Next-state and registered-output logic for IDLE/RUN/FIN.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    m_d     = m_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    mod_d   = mod_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          x_d     = x;
          m_d     = m_sel;
          r_d     = '0;
          cnt_d   = CW'(IN_W - 1);
          busy_d  = 1'b1;
          err_d   = 1'b0;
        end
      end
      RUN: begin
        x_d   = x_q << 1;
        r_d   = r_nxt;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = FIN;
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          err_d   = (m_q == '0);
          mod_d   = (m_q == '0) ? '0 : r_nxt;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      m_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      mod_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      m_q     <= m_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      mod_q   <= mod_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;
  assign mod  = mod_q;

endmodule
